// File: rtl/mode_sync_pkg.sv
// Shared types and constants for the frame-synchronous mode switch.
package mode_sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam int MODE_W   = 2;
    localparam int MODE_MAX = 3;

endpackage

// File: rtl/vs_edge_sync.sv
// Brings raw camera vsync into sys_clk and emits a one-cycle frame-start strobe
// on each transition into the active level.
module vs_edge_sync #(
    parameter logic VS_POL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic vs_i,
    output logic fs_o
);

    logic s1;
    logic s2;
    logic d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= vs_i ^ ~VS_POL;
            s2 <= s1;
            d  <= s2;
        end
    end

    // Synchronized level vs. its one-cycle delay gives the rising edge.
    assign fs_o = s2 & ~d;

endmodule

// File: rtl/mode_sync_ctrl.sv
// Defers debounced mode changes to the next camera frame start (or a vsync
// watchdog timeout) and opens an OSD window for a fixed number of frames.
module mode_sync_ctrl
    import mode_sync_pkg::*;
#(
    parameter logic [MODE_W-1:0] INIT_MODE  = 2'd0,
    parameter logic [7:0]        OSD_FRAMES = 8'd60,
    parameter logic [23:0]       VS_TIMEOUT = 24'd2_500_000,
    parameter logic              VS_POL     = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [3:0]        mode_req,
    input  logic              cam_vsync,
    output logic [MODE_W-1:0] mode_cur,
    output logic              mode_chg,
    output logic              osd_en,
    output logic              busy
);

    localparam logic [23:0] WDOG_MAX  = VS_TIMEOUT - 24'd1;
    localparam logic [7:0]  FCNT_LAST = OSD_FRAMES - 8'd1;

    function automatic logic [23:0] wdog_sat_inc(input logic [23:0] v);
        return (v == WDOG_MAX) ? v : v + 24'd1;
    endfunction

    state_t            state;
    logic [MODE_W-1:0] mode_pend;
    logic [23:0]       wdog;
    logic [7:0]        fcnt;
    logic              fs;
    logic              req_vld;
    logic              req_new;
    logic [MODE_W-1:0] req;

    vs_edge_sync #(
        .VS_POL (VS_POL)
    ) u_vs_edge_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .vs_i    (cam_vsync),
        .fs_o    (fs)
    );

    // Indices above MODE_MAX are treated as "no request".
    assign req     = mode_req[MODE_W-1:0];
    assign req_vld = (mode_req <= 4'(MODE_MAX));
    assign req_new = req_vld && (req != mode_cur);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            mode_cur  <= INIT_MODE;
            mode_pend <= INIT_MODE;
            mode_chg  <= 1'b0;
            osd_en    <= 1'b0;
            busy      <= 1'b0;
            wdog      <= 24'd0;
            fcnt      <= 8'd0;
        end else begin
            mode_chg <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_new) begin
                        mode_pend <= req;
                        wdog      <= 24'd0;
                        busy      <= 1'b1;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    wdog <= wdog_sat_inc(wdog);
                    // A request back to the current mode cancels, even on a frame start.
                    if (req_vld && !req_new) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (req_new) begin
                            mode_pend <= req;
                        end
                        if (fs || (wdog == WDOG_MAX)) begin
                            mode_cur <= mode_pend;
                            mode_chg <= 1'b1;
                            fcnt     <= 8'd0;
                            osd_en   <= 1'b1;
                            busy     <= 1'b0;
                            state    <= SHOW;
                        end
                    end
                end
                SHOW: begin
                    if (req_new) begin
                        mode_pend <= req;
                        wdog      <= 24'd0;
                        osd_en    <= 1'b0;
                        busy      <= 1'b1;
                        state     <= PEND;
                    end else if (fs) begin
                        if (fcnt == FCNT_LAST) begin
                            osd_en <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                end
                default: begin
                    osd_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
